// File: rtl/rgb2gray_pipe_if.sv
// ---------------------------------------------------------------------------
// rgb2gray_pipe_if
//   Pixel stream bundle for the RGB-to-gray converter: an input RGB pixel
//   channel and an output gray channel, each with a valid/ready handshake.
//
//   Signals
//     in_valid  : source has a pixel on in_r/in_g/in_b
//     in_ready  : converter accepts the pixel this cycle
//     in_r/g/b  : input channels, DW bits unsigned
//     out_valid : out_gray/out_last carry a result
//     out_ready : sink takes the result this cycle
//     out_gray  : gray result, DW bits unsigned
//     out_last  : result is the final pixel of a frame (qualifies out_valid)
//
//   Modports
//     slave  : converter side (consumes RGB, produces gray)
//     master : environment side (produces RGB, consumes gray)
// ---------------------------------------------------------------------------
interface rgb2gray_pipe_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_g;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_gray;
  logic          out_last;

  modport slave (
    input  in_valid, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_gray, out_last
  );

  modport master (
    output in_valid, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_gray, out_last
  );
endinterface

// File: rtl/rgb2gray_pipe.sv
// ---------------------------------------------------------------------------
// rgb2gray_pipe
//   Streaming fixed-point RGB to grayscale converter. One pixel per cycle,
//   three register stages, full backpressure. Each pixel carries its own luma
//   mode through the pipe. Output handshakes are counted to mark the last
//   pixel of each frame and to count completed frames.
//
//   Luma modes (coefficients have 8 fractional bits and sum to 256):
//     0 BT.601  (77,150,29)
//     1 BT.709  (54,183,19)
//     2 average (85,86,85)
//     3 green passthrough (gray = g, no rounding)
//
//   Stages
//     S1 : per-channel product ch*coef (DW+8 bits), mode and raw g
//     S2 : sum of the three products (DW+10 bits)
//     S3 : gray = sat((sum+128)>>8) or g; this is the output register
//   A pixel accepted in cycle c is presented on out_gray in cycle c+3.
//
//   Ports
//     i_clk       : clock, rising edge
//     i_rst       : asynchronous active-high reset
//     i_clr       : synchronous flush of pipeline and counters
//     i_mode      : luma mode, sampled with each accepted pixel
//     px          : pixel stream bundle (slave side)
//     o_frame_cnt : completed frames, wraps at 2^FCW
//     o_busy      : some stage holds a valid pixel
// ---------------------------------------------------------------------------
module rgb2gray_pipe #(
  parameter int DW        = 8,
  parameter int FRAME_PIX = 64,
  parameter int FCW       = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clr,
  input  logic [1:0]     i_mode,
  rgb2gray_pipe_if.slave px,
  output logic [FCW-1:0] o_frame_cnt,
  output logic           o_busy
);

  localparam int PW = DW + 8;   // product width
  localparam int SW = DW + 10;  // sum width
  localparam int CW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [SW-1:0] MAX_GRAY  = SW'((1 << DW) - 1);
  localparam logic [SW-1:0] ROUND_ADD = SW'(128);
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_PIX - 1);
  localparam logic [1:0]    MODE_G    = 2'd3;

  // Coefficient lookup, channel 0=r 1=g 2=b. Green passthrough zeroes all
  // products; the raw green value travels alongside instead.
  function automatic logic [7:0] coef_lut(input logic [1:0] m, input int ch);
    logic [7:0] c;
    c = 8'd0;
    case (m)
      2'd0: c = (ch == 0) ? 8'd77 : (ch == 1) ? 8'd150 : 8'd29;
      2'd1: c = (ch == 0) ? 8'd54 : (ch == 1) ? 8'd183 : 8'd19;
      2'd2: c = (ch == 1) ? 8'd86 : 8'd85;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake control: every stage shifts together whenever the output
  // register is empty or being drained.
  // -------------------------------------------------------------------------
  logic w_en;
  logic w_accept;
  logic w_hs;
  logic w_last;

  logic r_s1_valid;
  logic r_s2_valid;
  logic r_out_valid;

  assign w_en        = !r_out_valid || px.out_ready;
  assign px.in_ready = w_en && !i_clr;
  assign w_accept    = px.in_valid && px.in_ready;
  // A flush discards a pending output without counting it.
  assign w_hs        = r_out_valid && px.out_ready && !i_clr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (i_clr) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      // Bubbles move down the pipe as invalid stages; nothing collapses.
      r_s1_valid  <= w_accept;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
    end
  end

  // -------------------------------------------------------------------------
  // S1: per-channel multiply
  // -------------------------------------------------------------------------
  logic [DW-1:0] w_ch   [3];
  logic [7:0]    w_coef [3];
  logic [PW-1:0] r_prod [3];
  logic [1:0]    r_s1_mode;
  logic [DW-1:0] r_s1_g;

  assign w_ch[0] = px.in_r;
  assign w_ch[1] = px.in_g;
  assign w_ch[2] = px.in_b;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign w_coef[gi] = coef_lut(i_mode, gi);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_prod[gi] <= '0;
      end else if (w_en) begin
        r_prod[gi] <= PW'(w_ch[gi]) * PW'(w_coef[gi]);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_mode <= 2'd0;
      r_s1_g    <= '0;
    end else if (w_en) begin
      r_s1_mode <= i_mode;
      r_s1_g    <= px.in_g;
    end
  end

  // -------------------------------------------------------------------------
  // S2: sum of products
  // -------------------------------------------------------------------------
  logic [SW-1:0] r_s2_sum;
  logic [1:0]    r_s2_mode;
  logic [DW-1:0] r_s2_g;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_sum  <= '0;
      r_s2_mode <= 2'd0;
      r_s2_g    <= '0;
    end else if (w_en) begin
      r_s2_sum  <= SW'(r_prod[0]) + SW'(r_prod[1]) + SW'(r_prod[2]);
      r_s2_mode <= r_s1_mode;
      r_s2_g    <= r_s1_g;
    end
  end

  // -------------------------------------------------------------------------
  // S3: round, saturate, select; output register
  // -------------------------------------------------------------------------
  logic [SW-1:0] w_round;
  logic [DW-1:0] w_sat;
  logic [DW-1:0] w_gray;
  logic [DW-1:0] r_out_gray;

  // Coefficients sum to 256, so the rounded value cannot exceed full scale
  // for legal inputs; the clamp keeps the result well defined regardless.
  assign w_round = (r_s2_sum + ROUND_ADD) >> 8;
  assign w_sat   = (w_round > MAX_GRAY) ? MAX_GRAY[DW-1:0] : w_round[DW-1:0];
  assign w_gray  = (r_s2_mode == MODE_G) ? r_s2_g : w_sat;

  // Only real pixels overwrite the output; it holds while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_gray <= '0;
    end else if (w_en && r_s2_valid) begin
      r_out_gray <= w_gray;
    end
  end

  // -------------------------------------------------------------------------
  // Frame position tracking, advanced on output handshakes only
  // -------------------------------------------------------------------------
  logic [CW-1:0]  r_pix_cnt;
  logic [FCW-1:0] r_frame_cnt;

  assign w_last = (r_pix_cnt == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix_cnt   <= '0;
      r_frame_cnt <= '0;
    end else if (i_clr) begin
      r_pix_cnt   <= '0;
      r_frame_cnt <= '0;
    end else if (w_hs) begin
      if (w_last) begin
        r_pix_cnt   <= '0;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end else begin
        r_pix_cnt   <= r_pix_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign px.out_valid = r_out_valid;
  assign px.out_gray  = r_out_gray;
  // The counter only moves on a handshake, so this is stable during a stall.
  assign px.out_last  = r_out_valid && w_last;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_busy       = r_s1_valid || r_s2_valid || r_out_valid;

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// ---------------------------------------------------------------------------
// tb_rgb2gray_pipe
//   Scoreboard bench for rgb2gray_pipe. Two instances share the same stimulus:
//   one with 4-pixel frames and one with 1-pixel frames. Accepted pixels push
//   their expected gray value (from a plain arithmetic luma model) into a
//   queue; a monitor pops and compares on every output handshake and tracks
//   the expected frame position and frame count.
// ---------------------------------------------------------------------------
module tb_rgb2gray_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;

  logic [15:0] fc4, fc1;
  logic        busy4, busy1;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int log_gray[$];
  bit log_last[$];

  int mdl_cnt = 0, mdl_frames = 0, mdl_frames1 = 0;
  int hs_total = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;

  bit lat_arm = 1'b0;
  int first_acc = -1, first_out = -1, first_hs = -1, last_hs = -1, lat_hs = 0;

  bit         prev_stall = 1'b0;
  logic [7:0] prev_gray;
  logic       prev_last;

  rgb2gray_pipe_if #(.DW(8)) ifa ();
  rgb2gray_pipe_if #(.DW(8)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_r      = in_r;
  assign ifa.in_g      = in_g;
  assign ifa.in_b      = in_b;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_r      = in_r;
  assign ifb.in_g      = in_g;
  assign ifb.in_b      = in_b;
  assign ifb.out_ready = out_ready;

  rgb2gray_pipe #(.DW(8), .FRAME_PIX(4), .FCW(16)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_mode(mode),
    .px(ifa), .o_frame_cnt(fc4), .o_busy(busy4)
  );

  rgb2gray_pipe #(.DW(8), .FRAME_PIX(1), .FCW(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_mode(mode),
    .px(ifb), .o_frame_cnt(fc1), .o_busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference luma: weighted sum with round-to-nearest, clamped to 8 bits.
  function automatic int ref_gray(input int r, input int g, input int b, input int m);
    int v;
    case (m)
      0: v = (r * 77 + g * 150 + b * 29 + 128) / 256;
      1: v = (r * 54 + g * 183 + b * 19 + 128) / 256;
      2: v = (r * 85 + g * 86 + b * 85 + 128) / 256;
      default: v = g;
    endcase
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Input sampler: records what the DUT accepts at the coming edge.
  always @(negedge clk) begin
    if (!rst && in_valid && ifa.in_ready) begin
      exp_q.push_back(ref_gray(int'(in_r), int'(in_g), int'(in_b), int'(mode)));
      if (lat_arm && first_acc < 0) first_acc = cyc;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    int e;
    if (rst) begin
      exp_q.delete();
      mdl_cnt = 0; mdl_frames = 0; mdl_frames1 = 0;
      prev_stall = 1'b0;
    end else begin
      check("frame_cnt", 64'(fc4), 64'(mdl_frames[15:0]));
      check("frame_cnt_fp1", 64'(fc1), 64'(mdl_frames1[15:0]));
      if (prev_stall) begin
        check("stall_valid", 64'(ifa.out_valid), 64'd1);
        check("stall_gray", 64'(ifa.out_gray), 64'(prev_gray));
        check("stall_last", 64'(ifa.out_last), 64'(prev_last));
      end
      if (ifa.out_valid && !out_ready)
        check("in_ready_stalled", 64'(ifa.in_ready), 64'd0);
      if (lat_arm && first_out < 0 && ifa.out_valid) first_out = cyc;

      if (clr) begin
        exp_q.delete();
        mdl_cnt = 0; mdl_frames = 0; mdl_frames1 = 0;
        prev_stall = 1'b0;
      end else begin
        if (ifa.out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output actual=%0d required=none", ifa.out_gray);
          end else begin
            e = exp_q.pop_front();
            check("gray", 64'(ifa.out_gray), 64'(e));
            check("gray_fp1", 64'(ifb.out_gray), 64'(e));
          end
          check("last", 64'(ifa.out_last), 64'(mdl_cnt == 3));
          check("valid_fp1", 64'(ifb.out_valid), 64'd1);
          check("last_fp1", 64'(ifb.out_last), 64'd1);
          log_gray.push_back(int'(ifa.out_gray));
          log_last.push_back(ifa.out_last);
          if (mdl_cnt == 3) begin
            mdl_cnt = 0;
            mdl_frames++;
          end else begin
            mdl_cnt++;
          end
          mdl_frames1++;
          hs_total++;
          if (lat_arm) begin
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            lat_hs++;
          end
        end
        prev_stall = ifa.out_valid && !out_ready;
        prev_gray  = ifa.out_gray;
        prev_last  = ifa.out_last;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [1:0] m);
    int  n = 0;
    bit  done = 1'b0;
    in_r = r; in_g = g; in_b = b; mode = m; in_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = ifa.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("send_accept", 64'(done), 64'd1);
  endtask

  task automatic send_rand(input int count, input bit rand_mode);
    for (int i = 0; i < count; i++)
      send_px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), rand_mode ? 2'($urandom_range(0, 3)) : 2'(i % 4));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy4) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 64'(n < 300), 64'd1);
  endtask

  // One-cycle flush with a coincident pixel offered (it must be dropped).
  task automatic do_clr();
    clr = 1'b1;
    in_valid = 1'b1;
    in_r = 8'd200; in_g = 8'd100; in_b = 8'd50; mode = 2'd0;
    #1;
    check("clr_in_ready", 64'(ifa.in_ready), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", 64'(busy4), 64'd0);
    check("clr_out_valid", 64'(ifa.out_valid), 64'd0);
    check("clr_frame_cnt", 64'(fc4), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct { int r; int g; int b; int m; int exp; } dir_t;
  dir_t dir_tab[8];
  int   hs_before;

  initial begin
    dir_tab[0] = '{255, 255, 255, 0, 255};
    dir_tab[1] = '{255,   0,   0, 0,  77};
    dir_tab[2] = '{  0, 255,   0, 0, 149};
    dir_tab[3] = '{  0,   0, 255, 0,  29};
    dir_tab[4] = '{255, 255, 255, 1, 255};
    dir_tab[5] = '{255,   0,   0, 1,  54};
    dir_tab[6] = '{ 30,  60,  90, 2,  60};
    dir_tab[7] = '{ 10, 200,   7, 3, 200};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_out_gray", 64'(ifa.out_gray), 64'd0);
    check("rst_out_last", 64'(ifa.out_last), 64'd0);
    check("rst_frame_cnt", 64'(fc4), 64'd0);
    check("rst_busy", 64'(busy4), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed luma values
    log_gray.delete();
    for (int i = 0; i < 8; i++)
      send_px(8'(dir_tab[i].r), 8'(dir_tab[i].g), 8'(dir_tab[i].b), 2'(dir_tab[i].m));
    in_valid = 1'b0;
    wait_drain("directed");
    check("directed_count", 64'(log_gray.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_gray.size(); i++)
      check($sformatf("directed_%0d", i), 64'(log_gray[i]), 64'(dir_tab[i].exp));

    // Mode cycling per pixel
    send_rand(16, 1'b0);
    wait_drain("mode_cycle");

    // Latency and back-to-back throughput
    do_clr();
    first_acc = -1; first_out = -1; first_hs = -1; last_hs = -1; lat_hs = 0;
    lat_arm = 1'b1;
    send_rand(10, 1'b1);
    wait_drain("stream10");
    lat_arm = 1'b0;
    check("latency", 64'(first_out - first_acc), 64'd3);
    check("stream10_beats", 64'(lat_hs), 64'd10);
    check("stream10_consecutive", 64'(last_hs - first_hs), 64'd9);

    // Random backpressure
    hs_before = hs_total;
    rdy_rand = 1'b1;
    send_rand(20, 1'b1);
    wait_drain("backpressure");
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    check("backpressure_count", 64'(hs_total - hs_before), 64'd20);

    // Frame marking with 4-pixel frames
    do_clr();
    log_last.delete();
    send_rand(9, 1'b1);
    wait_drain("frame9");
    check("frame9_count", 64'(log_last.size()), 64'd9);
    for (int i = 0; i < 9 && i < log_last.size(); i++)
      check($sformatf("frame9_last_%0d", i), 64'(log_last[i]), 64'(i == 3 || i == 7));
    check("frame9_frame_cnt", 64'(fc4), 64'd2);
    check("frame9_frame_cnt_fp1", 64'(fc1), 64'd9);

    // Flush mid-frame with pixels in flight
    send_rand(2, 1'b1);
    check("preclr_busy", 64'(busy4), 64'd1);
    do_clr();
    log_last.delete();
    send_rand(4, 1'b1);
    wait_drain("postclr");
    check("postclr_last", 64'(log_last.size() == 4 && log_last[3] && !log_last[0]), 64'd1);
    check("postclr_frame_cnt", 64'(fc4), 64'd1);

    // Asynchronous reset with three pixels in flight
    send_rand(3, 1'b1);
    @(posedge clk);
    #2;
    check("prerst_out_valid", 64'(ifa.out_valid), 64'd1);
    check("prerst_frame_cnt", 64'(fc4), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("arst_busy", 64'(busy4), 64'd0);
    check("arst_frame_cnt", 64'(fc4), 64'd0);
    check("arst_out_gray", 64'(ifa.out_gray), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_rand(5, 1'b1);
    wait_drain("postrst");
    check("postrst_frame_cnt", 64'(fc4), 64'd1);
    check("postrst_frame_cnt_fp1", 64'(fc1), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
